piano_tone_gen: RTL and testbench
=================================

PIANO_TONE_GEN -- requirements
Module: piano_tone_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port key_out  input  16  debounced key levels from the matrix scanner; active-low, 1 = released.
REQ-005 SHALL have port key_pulse  input  16  one-cycle press pulses from the matrix scanner; active-high.
REQ-006 SHALL have port beep  output  1  square-wave tone to the buzzer.
REQ-007 SHALL have port note_idx  output  4  index of the key currently sounding.
REQ-008 SHALL have port note_on  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL map key i to half-period count HALF[i] = floor(CLK_HZ / (2*F[i])), where F = 262,294,330,349,392,440,494,523,587,659,698,784,880,988,1047,1175 Hz for i = 0..15.
REQ-010 SHALL use a 16-bit half-period counter; CLK_HZ SHALL be limited so that HALF[0] <= 65535.
REQ-011 SHALL implement states IDLE, PLAY, SWITCH and STOP.
REQ-012 IDLE: beep=0 and counter=0; on any key_pulse bit: note_idx = lowest set index, counter cleared, beep=1 on the next cycle, go to PLAY.
REQ-013 PLAY/SWITCH/STOP toggle point: when counter = HALF[note_idx]-1, counter clears; otherwise counter increments by 1.
REQ-014 PLAY: beep toggles at each toggle point.
REQ-015 PLAY: a key_pulse whose lowest set index differs from note_idx SHALL load pend_idx and go to SWITCH; a pulse equal to note_idx SHALL be ignored.
REQ-016 PLAY: key_out[note_idx]=1 with another key held SHALL load pend_idx = lowest held index and go to SWITCH; with no key held, go to STOP.
REQ-017 SWITCH: at the toggle point, note_idx <= pend_idx, counter clears, beep toggles, go to PLAY; the new pitch starts without a truncated half-cycle.
REQ-018 SWITCH: a new key_pulse SHALL overwrite pend_idx (lowest set index).
REQ-019 STOP: at the toggle point, beep <= 0 and go to IDLE; a key_pulse received in STOP SHALL load pend_idx and go to SWITCH.
REQ-020 Simultaneous key_pulse and release of the sounding key in the same cycle: key_pulse SHALL win (last-pressed priority).
REQ-021 Multiple key_pulse bits in one cycle: lowest index SHALL win.
REQ-022 note_idx SHALL hold its last value in IDLE.

Reset
REQ-023 On rst=1 at a clk edge: state=IDLE, counter=0, beep=0, note_idx=0, pend_idx=0, note_on=0; rst mid-tone SHALL silence beep on the next edge.
REQ-024 Inputs SHALL be ignored while rst=1.

Structure
REQ-025 Shared package piano_pkg SHALL hold: the state enum, the 16-entry frequency table F, the function computing HALF from CLK_HZ, and NUM_KEYS=16.
REQ-026 One sub-module, key_prio_enc (16-bit lowest-set-index encoder with valid flag), SHALL be instantiated twice: once for key_pulse and once for ~key_out.

Verification (CLK_HZ = 12_000_000)
REQ-027 Scenario: key_pulse[5] for 1 cycle in IDLE -> note_on=1, note_idx=5, beep high for 13636 cycles then low for 13636 cycles, repeating.
REQ-028 Scenario: key 5 sounding, key_pulse[0] mid-half-period -> beep keeps the 13636-cycle half, then note_idx=0 and half-period = 22900 cycles.
REQ-029 Scenario: key 0 sounding with key 15 held, key_out[0] rises -> after the current half ends, half-period = 5106 cycles, note_idx=15.
REQ-030 Scenario: sole key released while beep high -> beep falls at the toggle point, note_on=0 one cycle later, beep stays 0.
REQ-031 Scenario: key_pulse = 16'h0024 -> note_idx=2; same-cycle release of the sounding key with a pulse -> pulse index selected.
REQ-032 Scenario: rst asserted mid-tone -> beep=0, note_on=0, note_idx=0 after one edge; no toggling until the next key_pulse.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano tone generator: FSM states, the key
// frequency table and the half-period helper used to size the tone timer.
package piano_pkg;

    localparam int NUM_KEYS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_SWITCH = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Key frequencies in Hz, key 0 (C4) up to key 15 (D6).
    localparam int unsigned FREQ_HZ [NUM_KEYS] = '{
        262, 294, 330, 349, 392, 440, 494, 523,
        587, 659, 698, 784, 880, 988, 1047, 1175
    };

    // Clock cycles per half period of a key's square wave (rounded down).
    // CLK_HZ must keep the lowest key at or below 65535 so it fits the timer.
    function automatic logic [15:0] half_period(input int unsigned clk_hz,
                                                input logic [3:0]  key);
        return 16'(clk_hz / (2 * FREQ_HZ[key]));
    endfunction

endpackage

// File: rtl/key_prio_enc.sv
// Lowest-set-index priority encoder over the key vector, with a valid flag.
module key_prio_enc
    import piano_pkg::*;
(
    input  logic [NUM_KEYS-1:0] req,
    output logic                valid,
    output logic [3:0]          idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/piano_tone_gen.sv
// Square-wave buzzer driver for a 16-key keyboard. Newest press wins; pitch
// changes and note-off are deferred to the end of the current half period so
// the buzzer never sees a truncated half cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | silent, timer parked at zero, waiting for a press
// ST_PLAY   | sounding note_idx
// ST_SWITCH | still sounding note_idx, pend_idx takes over at next toggle
// ST_STOP   | still sounding note_idx, goes silent at next toggle
module piano_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 12_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_out,
    input  logic [NUM_KEYS-1:0] key_pulse,
    output logic                beep,
    output logic [3:0]          note_idx,
    output logic                note_on
);

    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  pend_idx;

    logic        pulse_vld;
    logic [3:0]  pulse_idx;
    logic        held_vld;
    logic [3:0]  held_idx;

    logic [15:0] half_m1_tab [NUM_KEYS];
    logic        at_toggle;
    logic [15:0] cnt_next;
    logic        beep_next;

    key_prio_enc u_pulse_enc (
        .req   (key_pulse),
        .valid (pulse_vld),
        .idx   (pulse_idx)
    );

    // key_out is active-low, so invert to get the set of keys held down.
    key_prio_enc u_held_enc (
        .req   (~key_out),
        .valid (held_vld),
        .idx   (held_idx)
    );

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_half
        assign half_m1_tab[g] = half_period(CLK_HZ, 4'(g)) - 16'd1;
    end

    assign at_toggle = (cnt == half_m1_tab[note_idx]);
    assign cnt_next  = at_toggle ? 16'd0 : cnt + 16'd1;
    assign beep_next = at_toggle ? ~beep : beep;
    assign note_on   = (state != ST_IDLE);

    // Tone FSM: half-period timer, buzzer output and note selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            beep     <= 1'b0;
            note_idx <= 4'd0;
            pend_idx <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt  <= 16'd0;
                    beep <= 1'b0;
                    if (pulse_vld) begin
                        note_idx <= pulse_idx;
                        beep     <= 1'b1;
                        state    <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    cnt  <= cnt_next;
                    beep <= beep_next;
                    // A fresh press beats a release seen in the same cycle.
                    if (pulse_vld && (pulse_idx != note_idx)) begin
                        pend_idx <= pulse_idx;
                        state    <= ST_SWITCH;
                    end else if (key_out[note_idx]) begin
                        if (held_vld) begin
                            pend_idx <= held_idx;
                            state    <= ST_SWITCH;
                        end else begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_SWITCH: begin
                    cnt  <= cnt_next;
                    beep <= beep_next;
                    if (pulse_vld) begin
                        pend_idx <= pulse_idx;
                    end
                    // A press landing on the toggle cycle is the newest key.
                    if (at_toggle) begin
                        note_idx <= pulse_vld ? pulse_idx : pend_idx;
                        state    <= ST_PLAY;
                    end
                end
                ST_STOP: begin
                    if (pulse_vld) begin
                        pend_idx <= pulse_idx;
                        cnt      <= cnt_next;
                        beep     <= beep_next;
                        state    <= ST_SWITCH;
                    end else if (at_toggle) begin
                        cnt   <= 16'd0;
                        beep  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piano_tone_gen.sv
// Self-checking bench for piano_tone_gen at 12 MHz: directed tone scenarios
// plus a randomized key phase, all checked cycle by cycle against a model.
module tb_piano_tone_gen;

    localparam int unsigned CLK_HZ = 12_000_000;

    int unsigned freq_tab [16] = '{262, 294, 330, 349, 392, 440, 494, 523,
                                   587, 659, 698, 784, 880, 988, 1047, 1175};
    int half_tab [16];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_out = 16'hFFFF;
    logic [15:0] key_pulse = 16'h0000;
    logic        beep;
    logic [3:0]  note_idx;
    logic        note_on;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model state: mode 0 silent, 1 sounding, 2 changing pitch, 3 stopping.
    int m_mode = 0;
    int m_cnt  = 0;
    int m_note = 0;
    int m_pend = 0;
    bit m_beep = 1'b0;

    always #5 clk = ~clk;

    piano_tone_gen #(.CLK_HZ(CLK_HZ)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_out   (key_out),
        .key_pulse (key_pulse),
        .beep      (beep),
        .note_idx  (note_idx),
        .note_on   (note_on)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick_half(input bit tp);
        if (tp) begin
            m_cnt  = 0;
            m_beep = !m_beep;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    // Behavioural model of the tone rules, stepped on each rising edge.
    always @(posedge clk) begin
        int pi;
        int hi;
        bit pv;
        bit tp;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_beep = 1'b0; m_note = 0; m_pend = 0;
        end else begin
            pi = lowest(key_pulse);
            pv = (pi >= 0);
            hi = lowest(~key_out);
            tp = (m_cnt == half_tab[m_note] - 1);
            case (m_mode)
                0: if (pv) begin
                    m_note = pi; m_cnt = 0; m_beep = 1'b1; m_mode = 1;
                end
                1: begin
                    tick_half(tp);
                    if (pv && pi != m_note) begin
                        m_pend = pi; m_mode = 2;
                    end else if (key_out[m_note]) begin
                        if (hi >= 0) begin
                            m_pend = hi; m_mode = 2;
                        end else begin
                            m_mode = 3;
                        end
                    end
                end
                2: begin
                    if (pv) m_pend = pi;
                    tick_half(tp);
                    if (tp) begin
                        m_note = m_pend; m_mode = 1;
                    end
                end
                default: begin
                    if (pv) begin
                        m_pend = pi; tick_half(tp); m_mode = 2;
                    end else if (tp) begin
                        m_beep = 1'b0; m_cnt = 0; m_mode = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_beep", beep, m_beep);
            check("cyc_note_on", note_on, m_mode != 0);
            check("cyc_note_idx", note_idx, m_note);
        end
    end

    // Caller sits on a falling edge; the press is sampled on the next rising edge.
    task automatic press(input logic [15:0] m);
        key_pulse = m;
        key_out   = key_out & ~m;
        @(negedge clk);
        key_pulse = 16'h0000;
    endtask

    // Count falling edges until beep changes; optionally release a key at cycle act_at.
    task automatic wait_change(input int budget, input int act_at, input int act_key, output int n);
        logic lvl;
        lvl = beep;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (n == act_at) key_out[act_key] = 1'b1;
            if (beep !== lvl) break;
        end
    endtask

    initial begin
        int n;
        int toggles;
        logic prev;
        for (int i = 0; i < 16; i++) half_tab[i] = int'(CLK_HZ / (2 * freq_tab[i]));

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_beep", beep, 0);
        check("reset_note_on", note_on, 0);
        check("reset_note_idx", note_idx, 0);

        // Single press of key 5: 440 Hz, 13636-cycle halves.
        press(16'h0020);
        check("s27_note_on", note_on, 1);
        check("s27_note_idx", note_idx, 5);
        check("s27_beep_hi", beep, 1);
        wait_change(20000, -1, 0, n);
        check("s27_high_len", n, 13636);
        wait_change(20000, -1, 0, n);
        check("s27_low_len", n, 13636);

        // Press key 0 mid-half while releasing key 5: current half completes.
        repeat (13000) @(negedge clk);
        key_out[5] = 1'b1;
        press(16'h0001);
        check("s28_still_5", note_idx, 5);
        wait_change(20000, -1, 0, n);
        check("s28_remain", n, 635);
        check("s28_note_idx", note_idx, 0);

        // Hold key 15, release key 0 late in its half: 15 takes over at the toggle.
        key_out[15] = 1'b0;
        wait_change(30000, 22000, 0, n);
        check("s29_old_half", n, 22900);
        check("s29_note_idx", note_idx, 15);

        // Release key 15 while beep is high: falls at the toggle and stays silent.
        wait_change(10000, 100, 15, n);
        check("s30_fall_len", n, 5106);
        @(negedge clk);
        check("s30_note_on", note_on, 0);
        check("s30_note_hold", note_idx, 15);
        toggles = 0;
        prev = beep;
        repeat (500) begin
            @(negedge clk);
            if (beep !== prev) toggles++;
            prev = beep;
        end
        check("s30_silent", toggles, 0);

        // Multi-bit press picks the lowest index.
        press(16'h0024);
        check("s31_lowest", note_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        key_out = 16'hFFFF;
        press(16'h6000);
        check("s31_note13", note_idx, 13);
        // Release of the sounding key with a same-cycle press: the press wins.
        key_out[13] = 1'b1;
        press(16'h8000);
        wait_change(8000, -1, 0, n);
        check("s31_half13", n, half_tab[13] - 1);
        check("s31_pulse_wins", note_idx, 15);

        // Reset mid-tone, with a press offered during reset that must be ignored.
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        key_pulse = 16'h0001;
        @(negedge clk);
        rst = 1'b0;
        key_pulse = 16'h0000;
        check("s32_beep", beep, 0);
        check("s32_note_on", note_on, 0);
        check("s32_note_idx", note_idx, 0);
        toggles = 0;
        prev = beep;
        repeat (2000) begin
            @(negedge clk);
            if (beep !== prev) toggles++;
            prev = beep;
        end
        check("s32_quiet", toggles, 0);

        // Randomized presses and releases, checked by the model every cycle.
        for (int it = 0; it < 30; it++) begin
            int gap;
            int act;
            int k;
            logic [15:0] msk;
            gap = int'($urandom_range(200, 20));
            repeat (gap) @(negedge clk);
            act = int'($urandom_range(3, 0));
            k = int'($urandom_range(15, 0));
            case (act)
                0: press(16'h0001 << k);
                1: key_out[k] = 1'b1;
                2: begin
                    msk = 16'($urandom);
                    if (msk == 16'h0000) msk = 16'h0100;
                    press(msk);
                end
                default: begin
                    key_out[m_note] = 1'b1;
                    if (k == m_note) k = (k + 1) % 16;
                    press(16'h0001 << k);
                end
            endcase
        end
        repeat (50) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
